// File: rtl/hkspi_bus_bridge_pkg.sv
// Shared types and constants for the housekeeping SPI register bridge.
// FSM encoding, reserved-address limit, timeout read value, ID byte lookup.
package hkspi_bus_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_LOCAL = 2'd3
    } state_e;

    // Addresses below this are answered locally (mode/ID bytes)
    localparam logic [7:0] RSV_LIMIT = 8'd8;

    // Returned to the SPI slave when a bus read times out
    localparam logic [7:0] TO_RDATA = 8'hFF;

    // ID byte for reserved address 0..7
    function automatic logic [7:0] id_byte(
        input logic [2:0]  a,
        input logic [11:0] mfgr,
        input logic [7:0]  prod,
        input logic [31:0] mask
    );
        logic [7:0] r;
        r = 8'h00;
        unique case (a)
            3'd0: r = 8'h00;
            3'd1: r = mfgr[7:0];
            3'd2: r = {4'h0, mfgr[11:8]};
            3'd3: r = prod;
            3'd4: r = mask[31:24];
            3'd5: r = mask[23:16];
            3'd6: r = mask[15:8];
            3'd7: r = mask[7:0];
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hkspi_bus_bridge_sync.sv
// Multi-flop synchronizer for an SCK-domain strobe, with a one-cycle
// pulse on each rising edge seen at the synchronizer output.
module hkspi_bus_bridge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;
    logic              last_q;
    logic              last_d;

    // Shift the async level in; remember the previous synchronized value
    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d_i};
        last_d  = chain_q[STAGES-1];
    end

    // Synchronizer and edge-history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
            last_q  <= 1'b0;
        end else begin
            chain_q <= chain_d;
            last_q  <= last_d;
        end
    end

    assign rise_o = chain_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/hkspi_bus_bridge.sv
// Housekeeping SPI register interface to register-bus bridge.
// Optional bus-ack timeout: define HKSPI_BRIDGE_TIMEOUT_EN.
module hkspi_bus_bridge
    import hkspi_bus_bridge_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [11:0] MFGR_ID     = 12'h456,
    parameter logic [7:0]  PROD_ID     = 8'h00,
    parameter logic [31:0] MASK_ID     = 32'h0,
    parameter int          TIMEOUT_CYC = 255
) (
    input  logic       wb_clk_i,
    input  logic       wb_rstn_i,
    input  logic       spi_wrstb,
    input  logic       spi_rdstb,
    input  logic [7:0] spi_addr,
    input  logic [7:0] spi_odata,
    output logic [7:0] spi_idata,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_wdata,
    output logic       bus_we,
    output logic       bus_re,
    input  logic       bus_ack,
    input  logic [7:0] bus_rdata,
    output logic       bus_err
);

    logic       wr_ev;
    logic       rd_ev;

    state_e     state_q,   state_d;
    logic [7:0] addr_q,    addr_d;
    logic [7:0] wdata_q,   wdata_d;
    logic       we_q,      we_d;
    logic       re_q,      re_d;
    logic [7:0] idata_q,   idata_d;
    logic       pend_wr_q, pend_wr_d;
    logic       pend_rd_q, pend_rd_d;
    logic       clr_wr;
    logic       clr_rd;
    logic       to_hit;

`ifdef HKSPI_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    cfg_ok: assert property (@(posedge wb_clk_i)
        (SYNC_STAGES >= 2) && (TIMEOUT_CYC >= 1));

    hkspi_bus_bridge_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clk    (wb_clk_i),
        .rst_n  (wb_rstn_i),
        .d_i    (spi_wrstb),
        .rise_o (wr_ev)
    );

    hkspi_bus_bridge_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clk    (wb_clk_i),
        .rst_n  (wb_rstn_i),
        .d_i    (spi_rdstb),
        .rise_o (rd_ev)
    );

`ifdef HKSPI_BRIDGE_TIMEOUT_EN
    // Ack-wait counter: runs only while a bus request is outstanding
    always_comb begin
        cnt_d  = '0;
        to_hit = 1'b0;
        if (state_q == ST_WRITE || state_q == ST_READ) begin
            cnt_d  = cnt_q + 16'd1;
            to_hit = (cnt_q == TO_LAST) && !bus_ack;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    // Next-state, request and read-data computation
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        re_d    = re_q;
        idata_d = idata_q;
        clr_wr  = 1'b0;
        clr_rd  = 1'b0;
`ifdef HKSPI_BRIDGE_TIMEOUT_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pend_wr_q) begin
                    addr_d  = spi_addr;
                    wdata_d = spi_odata;
                    we_d    = (spi_addr >= RSV_LIMIT);
                    state_d = ST_WRITE;
                end else if (pend_rd_q) begin
                    addr_d = spi_addr;
                    if (spi_addr < RSV_LIMIT) begin
                        state_d = ST_LOCAL;
                    end else begin
                        re_d    = 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (addr_q < RSV_LIMIT) begin
                    clr_wr  = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus_ack) begin
                    we_d    = 1'b0;
                    clr_wr  = 1'b1;
                    state_d = ST_IDLE;
                end else if (to_hit) begin
                    we_d    = 1'b0;
                    clr_wr  = 1'b1;
                    state_d = ST_IDLE;
`ifdef HKSPI_BRIDGE_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end
            ST_READ: begin
                if (bus_ack) begin
                    idata_d = bus_rdata;
                    re_d    = 1'b0;
                    clr_rd  = 1'b1;
                    state_d = ST_IDLE;
                end else if (to_hit) begin
                    idata_d = TO_RDATA;
                    re_d    = 1'b0;
                    clr_rd  = 1'b1;
                    state_d = ST_IDLE;
`ifdef HKSPI_BRIDGE_TIMEOUT_EN
                    err_d   = 1'b1;
`endif
                end
            end
            ST_LOCAL: begin
                idata_d = id_byte(addr_q[2:0], MFGR_ID, PROD_ID, MASK_ID);
                clr_rd  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pend_wr_d = wr_ev | (pend_wr_q & ~clr_wr);
        pend_rd_d = rd_ev | (pend_rd_q & ~clr_rd);
    end

    // FSM state, pending flags and registered outputs
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= 8'h00;
            wdata_q   <= 8'h00;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            idata_q   <= 8'h00;
            pend_wr_q <= 1'b0;
            pend_rd_q <= 1'b0;
`ifdef HKSPI_BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            idata_q   <= idata_d;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
`ifdef HKSPI_BRIDGE_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    assign spi_idata = idata_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_we    = we_q;
    assign bus_re    = re_q;
`ifdef HKSPI_BRIDGE_TIMEOUT_EN
    assign bus_err   = err_q;
`else
    assign bus_err   = 1'b0;
`endif

endmodule

// File: tb/tb_hkspi_bus_bridge.sv
// Bench for hkspi_bus_bridge: directed table, hand sequences, random ops
// against a register-map reference model and a memory-backed bus responder.
module tb_hkspi_bus_bridge;

    localparam int          SYNC = 2;
    localparam logic [11:0] MFGR = 12'h456;
    localparam logic [7:0]  PROD = 8'h11;
    localparam logic [31:0] MASK = 32'hDEADBEEF;
    localparam int          TO   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wrstb = 1'b0;
    logic       rdstb = 1'b0;
    logic [7:0] saddr = 8'h00;
    logic [7:0] sodata = 8'h00;
    logic [7:0] idata;
    logic [7:0] baddr;
    logic [7:0] bwdata;
    logic       bwe;
    logic       bre;
    logic       back = 1'b0;
    logic [7:0] brdata = 8'h00;
    logic       berr;

    hkspi_bus_bridge #(
        .SYNC_STAGES (SYNC),
        .MFGR_ID     (MFGR),
        .PROD_ID     (PROD),
        .MASK_ID     (MASK),
        .TIMEOUT_CYC (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rst_n),
        .spi_wrstb (wrstb),
        .spi_rdstb (rdstb),
        .spi_addr  (saddr),
        .spi_odata (sodata),
        .spi_idata (idata),
        .bus_addr  (baddr),
        .bus_wdata (bwdata),
        .bus_we    (bwe),
        .bus_re    (bre),
        .bus_ack   (back),
        .bus_rdata (brdata),
        .bus_err   (berr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
    } txn_t;

    typedef struct {
        bit         we;
        logic [7:0] addr;
        logic [7:0] data;
        int         dly;
        int         exp_n;
        logic [7:0] exp_id;
    } vec_t;

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    txn_t       log_q[$];
    int         ack_dly = 0;
    bit         ack_never = 1'b0;
    int         wait_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Register map as seen from SPI: ID bytes below 8
    function automatic logic [7:0] id_exp(input logic [7:0] a);
        logic [31:0] m;
        m = MASK;
        if (a == 8'd0) return 8'h00;
        if (a == 8'd1) return MFGR[7:0];
        if (a == 8'd2) return {4'h0, MFGR[11:8]};
        if (a == 8'd3) return PROD;
        return 8'((m >> (8 * (7 - int'(a)))) & 32'hFF);
    endfunction

    // Bus slave: acks after ack_dly cycles, serves/updates mem, logs txns
    initial begin
        forever begin
            @(negedge clk);
            if (back) begin
                back = 1'b0;
                brdata = 8'($urandom);
            end else if ((bwe || bre) && rst_n && !ack_never) begin
                if (wait_cnt >= ack_dly) begin
                    back = 1'b1;
                    wait_cnt = 0;
                    if (bwe) begin
                        mem[baddr] = bwdata;
                        log_q.push_back('{1'b1, baddr, bwdata});
                        brdata = 8'($urandom);
                    end else begin
                        brdata = mem[baddr];
                        log_q.push_back('{1'b0, baddr, mem[baddr]});
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                brdata = 8'($urandom);
            end
        end
    end

    // Protocol watch: exclusive requests, stable addr/data while requesting
    logic       p_req = 1'b0;
    logic [7:0] p_addr = 8'h00;
    logic [7:0] p_wdata = 8'h00;
    initial begin
        forever begin
            @(negedge clk);
            if (bwe && bre) chk("we_re_excl", 1, 0);
            if (p_req && (bwe || bre)) begin
                chk("addr_stable", baddr, p_addr);
                if (bwe) chk("wdata_stable", bwdata, p_wdata);
            end
            p_req = bwe | bre;
            p_addr = baddr;
            p_wdata = bwdata;
        end
    end

    task automatic do_op(input bit we, input logic [7:0] a,
                         input logic [7:0] d, input int dly,
                         input int exp_n, input logic [7:0] exp_id,
                         input string tag);
        int n0;
        ack_dly = dly;
        n0 = log_q.size();
        @(negedge clk);
        #2;
        saddr = a;
        sodata = d;
        if (we) wrstb = 1'b1;
        else rdstb = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        wrstb = 1'b0;
        rdstb = 1'b0;
        repeat (26) @(negedge clk);
        chk({tag, "_ntxn"}, log_q.size() - n0, exp_n);
        if (exp_n == 1 && log_q.size() > n0) begin
            chk({tag, "_txn_we"}, log_q[n0].we, we);
            chk({tag, "_txn_addr"}, log_q[n0].addr, a);
            if (we) chk({tag, "_txn_data"}, log_q[n0].data, d);
        end
        if (!we) chk({tag, "_idata"}, idata, exp_id);
        chk({tag, "_err"}, berr, 0);
    endtask

    vec_t vt[14];

    initial begin
        int k;
        int n0;
        logic [7:0] id_before;

        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end

        vt[0]  = '{1'b1, 8'h10, 8'hA5, 3, 1, 8'h00};
        vt[1]  = '{1'b0, 8'h03, 8'h00, 0, 0, 8'h11};
        vt[2]  = '{1'b1, 8'h05, 8'h33, 0, 0, 8'h00};
        vt[3]  = '{1'b0, 8'h05, 8'h00, 0, 0, 8'hAD};
        vt[4]  = '{1'b0, 8'h10, 8'h00, 0, 1, 8'hA5};
        vt[5]  = '{1'b0, 8'h00, 8'h00, 0, 0, 8'h00};
        vt[6]  = '{1'b0, 8'h01, 8'h00, 0, 0, 8'h56};
        vt[7]  = '{1'b0, 8'h02, 8'h00, 0, 0, 8'h04};
        vt[8]  = '{1'b0, 8'h04, 8'h00, 0, 0, 8'hDE};
        vt[9]  = '{1'b0, 8'h07, 8'h00, 0, 0, 8'hEF};
        vt[10] = '{1'b1, 8'hFF, 8'h3C, 1, 1, 8'h00};
        vt[11] = '{1'b0, 8'hFF, 8'h00, 2, 1, 8'h3C};
        vt[12] = '{1'b0, 8'h08, 8'h00, 4, 1, 8'h52};
        vt[13] = '{1'b0, 8'h06, 8'h00, 0, 0, 8'hBE};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_idata", idata, 0);
        chk("rst_we", bwe, 0);
        chk("rst_re", bre, 0);
        chk("rst_err", berr, 0);
        chk("rst_addr", baddr, 0);
        chk("rst_wdata", bwdata, 0);
        #2;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            do_op(vt[i].we, vt[i].addr, vt[i].data, vt[i].dly,
                  vt[i].exp_n, vt[i].exp_id, $sformatf("vec%0d", i));
            if (vt[i].we && vt[i].addr >= 8'd8)
                ref_mem[vt[i].addr] = vt[i].data;
        end

        // Strobe-to-request latency on a write
        @(negedge clk);
        #2;
        saddr = 8'h30;
        sodata = 8'h9C;
        ack_dly = 2;
        wrstb = 1'b1;
        k = 0;
        while (!bwe && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("wr_latency", k, SYNC + 2);
        #2;
        wrstb = 1'b0;
        repeat (20) @(negedge clk);
        ref_mem[8'h30] = 8'h9C;
        chk("lat_wr_mem", mem[8'h30], 8'h9C);

        // Local read latency: strobe rise to idata update
        @(negedge clk);
        #2;
        saddr = 8'h01;
        rdstb = 1'b1;
        k = 0;
        while (idata !== 8'h56 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("local_rd_latency", k, SYNC + 3);
        #2;
        rdstb = 1'b0;
        repeat (10) @(negedge clk);

        // Stray ack while idle is ignored
        n0 = log_q.size();
        id_before = idata;
        #2;
        back = 1'b1;
        brdata = 8'hE7;
        repeat (4) @(negedge clk);
        chk("stray_ack_idata", idata, id_before);
        chk("stray_ack_req", {bwe, bre}, 0);
        chk("stray_ack_ntxn", log_q.size() - n0, 0);

        // Write and read strobes rising together: write first
        n0 = log_q.size();
        ack_dly = 1;
        @(negedge clk);
        #2;
        saddr = 8'h20;
        sodata = 8'h77;
        wrstb = 1'b1;
        rdstb = 1'b1;
        repeat (4) @(negedge clk);
        #2;
        wrstb = 1'b0;
        rdstb = 1'b0;
        repeat (40) @(negedge clk);
        ref_mem[8'h20] = 8'h77;
        chk("both_ntxn", log_q.size() - n0, 2);
        if (log_q.size() - n0 == 2) begin
            chk("both_first_we", log_q[n0].we, 1);
            chk("both_first_addr", log_q[n0].addr, 8'h20);
            chk("both_first_data", log_q[n0].data, 8'h77);
            chk("both_second_we", log_q[n0+1].we, 0);
            chk("both_second_addr", log_q[n0+1].addr, 8'h20);
        end
        chk("both_idata", idata, 8'h77);

        // Randomized ops against the register-map model
        for (int i = 0; i < 40; i++) begin
            bit         w;
            logic [7:0] a;
            logic [7:0] d;
            int         en;
            logic [7:0] ei;
            w = 1'($urandom);
            a = ($urandom_range(3) == 0) ? 8'($urandom_range(7))
                                         : 8'($urandom);
            d = 8'($urandom);
            en = (a >= 8'd8) ? 1 : 0;
            ei = (a < 8'd8) ? id_exp(a) : ref_mem[a];
            do_op(w, a, d, $urandom_range(4), en, ei,
                  $sformatf("rnd%0d", i));
            if (w && a >= 8'd8) ref_mem[a] = d;
        end

`ifdef HKSPI_BRIDGE_TIMEOUT_EN
        // Read with no ack: request held TO cycles then dropped
        ack_never = 1'b1;
        @(negedge clk);
        #2;
        saddr = 8'h40;
        rdstb = 1'b1;
        k = 0;
        while (!bre && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("to_re_seen", bre, 1);
        k = 0;
        while (bre && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("to_re_cycles", k, TO);
        chk("to_idata", idata, 8'hFF);
        chk("to_err", berr, 1);
        #2;
        rdstb = 1'b0;
        ack_never = 1'b0;
        repeat (10) @(negedge clk);
`endif

        // Reset during an outstanding bus read
        ack_never = 1'b1;
        @(negedge clk);
        #2;
        saddr = 8'h41;
        rdstb = 1'b1;
        k = 0;
        while (!bre && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rstmid_re_seen", bre, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_re", bre, 0);
        chk("rstmid_we", bwe, 0);
        chk("rstmid_idata", idata, 0);
        chk("rstmid_addr", baddr, 0);
        chk("rstmid_err", berr, 0);
        rdstb = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        ack_never = 1'b0;
        repeat (3) @(negedge clk);
        do_op(1'b0, 8'h10, 8'h00, 1, 1, ref_mem[8'h10], "post_rst_rd");
        do_op(1'b0, 8'h03, 8'h00, 0, 0, 8'h11, "post_rst_local");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
